// File: rtl/axil_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_resp_pkg
// Brief    : Shared response codes, FSM encodings and address decode for the
//            AXI4-Lite register responder.
// Revision : 1.0
// ============================================================================
package axil_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Word index of a byte address; the low two bits are dropped, never faulted.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_resp_regbank.sv
`default_nettype none
// ============================================================================
// Module   : axil_resp_regbank
// Brief    : Writable register array, byte-strobe merge, status read mux and
//            write-commit pulse. AXIL_RESP_WSTRB_EN enables per-lane writes.
// Revision : 1.0
// ============================================================================
module axil_resp_regbank
  import axil_resp_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_wr_strb,
  input  logic [IDX_W-1:0]      i_rd_idx,
  input  logic [31:0]           i_status,
  output logic [31:0]           o_rd_data,
  output logic [32*NREGS-33:0]  o_reg_out,
  output logic                  o_wr_pulse,
  output logic [IDX_W-1:0]      o_wr_index
);

  logic [31:0]      regs_q [NREGS-1];
  logic [31:0]      regs_d [NREGS-1];
  logic             wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0] wr_index_q, wr_index_d;
  logic [3:0]       w_strb;

`ifdef AXIL_RESP_WSTRB_EN
  assign w_strb = i_wr_strb;
`else
  // Strobes forced on: every write replaces the full word.
  assign w_strb = i_wr_strb | 4'hF;
`endif

  always_comb begin
    wr_pulse_d = i_wr_en;
    wr_index_d = i_wr_en ? i_wr_idx : wr_index_q;
    for (int i = 0; i < NREGS - 1; i++) begin
      regs_d[i] = regs_q[i];
      if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) regs_d[i][8*b +: 8] = i_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS - 1; i++) regs_q[i] <= '0;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
    end
  end

  // Reads see the current (pre-write) contents, so a same-edge write is not forwarded.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_idx == IDX_W'(NREGS - 1)) begin
      o_rd_data = i_status;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (i_rd_idx == IDX_W'(i)) o_rd_data = regs_q[i];
      end
    end
  end

  for (genvar g = 0; g < NREGS - 1; g++) begin : g_flat
    assign o_reg_out[32*g +: 32] = regs_q[g];
  end

  assign o_wr_pulse = wr_pulse_q;
  assign o_wr_index = wr_index_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_responder
// Brief    : AXI4-Lite register responder with independent read/write FSMs;
//            bad or read-only targets answer SLVERR. AXIL_RESP_WSTRB_EN
//            enables byte strobes.
// Revision : 1.0
// ============================================================================
module axi_lite_reg_responder
  import axil_resp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NREGS  = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDR_W-1:0]         AWADDR,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic [31:0]               WDATA,
  input  logic [3:0]                WSTRB,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [1:0]                BRESP,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  input  logic [ADDR_W-1:0]         ARADDR,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [31:0]               RDATA,
  output logic [1:0]                RRESP,
  input  logic [31:0]               Status_In,
  output logic [32*NREGS-33:0]      Reg_Out,
  output logic                      Wr_Pulse,
  output logic [$clog2(NREGS)-1:0]  Wr_Index
);

  localparam int          IDX_W      = $clog2(NREGS);
  localparam logic [31:0] c_wr_limit = NREGS - 1;
  localparam logic [31:0] c_rd_limit = NREGS;

  logic [0:0]        w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [0:0]        r_state_q, r_state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              w_aw_fire, w_w_fire, w_commit, w_wr_valid, w_rd_valid;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [31:0]       w_wr_data, w_wr_idx_full, w_rd_idx_full, w_rd_data;
  logic [3:0]        w_wr_strb;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // A beat captured earlier takes priority over the live bus for the commit.
  always_comb begin
    w_aw_fire     = AWVALID && AWREADY;
    w_w_fire      = WVALID && WREADY;
    w_wr_addr     = aw_held_q ? awaddr_q : AWADDR;
    w_wr_data     = w_held_q ? wdata_q : WDATA;
    w_wr_strb     = w_held_q ? wstrb_q : WSTRB;
    w_wr_idx_full = addr_to_index(32'(w_wr_addr));
    w_wr_valid    = w_wr_idx_full < c_wr_limit;
    w_commit      = (w_state_q == W_IDLE) && (aw_held_q || w_aw_fire) && (w_held_q || w_w_fire);

    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (w_w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if (w_commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = w_wr_valid ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
    WREADY  = (w_state_q == W_IDLE) && !w_held_q;
    BVALID  = (w_state_q == W_RESP);
    BRESP   = bresp_q;
  end

  always_comb begin
    w_rd_idx_full = addr_to_index(32'(ARADDR));
    w_rd_valid    = w_rd_idx_full < c_rd_limit;
    r_state_d     = r_state_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          rdata_d   = w_rd_valid ? w_rd_data : 32'h0;
          rresp_d   = w_rd_valid ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: if (RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (r_state_q == R_IDLE);
    RVALID  = (r_state_q == R_DATA);
    RDATA   = rdata_q;
    RRESP   = rresp_q;
  end

  axil_resp_regbank #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_regbank (
    .clk        (ACLK),
    .rst        (ARESET),
    .i_wr_en    (w_commit && w_wr_valid),
    .i_wr_idx   (w_wr_idx_full[IDX_W-1:0]),
    .i_wr_data  (w_wr_data),
    .i_wr_strb  (w_wr_strb),
    .i_rd_idx   (w_rd_idx_full[IDX_W-1:0]),
    .i_status   (Status_In),
    .o_rd_data  (w_rd_data),
    .o_reg_out  (Reg_Out),
    .o_wr_pulse (Wr_Pulse),
    .o_wr_index (Wr_Index)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_responder
// Brief    : Directed scoreboard bench for axi_lite_reg_responder; follows
//            AXIL_RESP_WSTRB_EN to choose strobe expectations.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_reg_responder;

  localparam int ADDR_W = 8;
  localparam int NREGS  = 8;
`ifdef AXIL_RESP_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic                 AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic                 ARVALID, ARREADY, RVALID, RREADY;
  logic [ADDR_W-1:0]    AWADDR, ARADDR;
  logic [31:0]          WDATA, RDATA, Status_In;
  logic [3:0]           WSTRB;
  logic [1:0]           BRESP, RRESP;
  logic [32*NREGS-33:0] Reg_Out;
  logic                 Wr_Pulse;
  logic [2:0]           Wr_Index;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        bq[$];
  exp_t        rq[$];
  logic [31:0] model [NREGS-1];
  int          checks   = 0;
  int          failures = 0;

  axi_lite_reg_responder #(.ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .Status_In(Status_In), .Reg_Out(Reg_Out),
    .Wr_Pulse(Wr_Pulse), .Wr_Index(Wr_Index)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NREGS - 1; i++) chk(tag, Reg_Out[32*i +: 32], model[i]);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold);
    exp_t e;
    int   idx;
    int   n;
    idx    = int'(a) >> 2;
    e.data = 32'h0;
    e.resp = (idx < NREGS - 1) ? 2'b00 : 2'b10;
    bq.push_back(e);
    if (e.resp == 2'b00)
      for (int b = 0; b < 4; b++) if (s[b] || !STRB_EN) model[idx][8*b +: 8] = d[8*b +: 8];

    @(negedge ACLK);
    WVALID = 1'b1; WDATA = d; WSTRB = s;
    if (lead == 0) begin AWVALID = 1'b1; AWADDR = a; end
    @(negedge ACLK);
    WVALID = 1'b0; AWVALID = 1'b0;
    if (lead > 0) begin
      for (int j = 0; j < lead - 1; j++) begin
        chk("wready_after_w", WREADY, 0);
        chk("bvalid_early", BVALID, 0);
        @(negedge ACLK);
      end
      AWVALID = 1'b1; AWADDR = a;
      @(negedge ACLK);
      AWVALID = 1'b0;
    end

    n = 0;
    while (BVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    chk("bvalid_seen", BVALID, 1);
    e = bq.pop_front();
    chk("bresp", BRESP, e.resp);
    chk("wr_pulse", Wr_Pulse, (e.resp == 2'b00));
    if (e.resp == 2'b00) chk("wr_index", Wr_Index, idx);
    chk_regs("reg_out_after_write");

    for (int j = 0; j < hold; j++) begin
      @(negedge ACLK);
      chk("bvalid_hold", BVALID, 1);
      chk("bresp_hold", BRESP, e.resp);
      chk("wready_hold", WREADY, 0);
      chk("wr_pulse_single", Wr_Pulse, 0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_clear", BVALID, 0);
    chk("awready_back", AWREADY, 1);
    chk("wready_back", WREADY, 1);
    chk("wr_pulse_single", Wr_Pulse, 0);
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
    exp_t e;
    int   n;
    e.data = ed; e.resp = er;
    rq.push_back(e);
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = a;
    @(negedge ACLK);
    ARVALID = 1'b0;
    n = 0;
    while (RVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    chk("rvalid_seen", RVALID, 1);
    e = rq.pop_front();
    chk("rdata", RDATA, e.data);
    chk("rresp", RRESP, e.resp);
    chk("arready_busy", ARREADY, 0);
    @(negedge ACLK);
    chk("rdata_hold", RDATA, e.data);
    chk("rvalid_hold", RVALID, 1);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("rvalid_clear", RVALID, 0);
    chk("arready_back", ARREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < NREGS - 1; i++) model[i] = 32'h0;
    ARESET = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = 4'hF;
    BREADY = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
    Status_In = 32'h0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_wr_pulse", Wr_Pulse, 0);
    chk("rst_wr_index", Wr_Index, 0);
    chk_regs("rst_reg_out");

    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(8'h04, 32'hDEADBEEF, 2'b00);

    axi_write(8'h10, 32'hCAFE0001, 4'hF, 3, 5);
    axi_write(8'h18, 32'h600DF00D, 4'hF, 0, 1);

    axi_write(8'h1C, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(8'h40, 32'h55555555, 4'hF, 2, 0);
    axi_read(8'h40, 32'h0, 2'b10);
    Status_In = 32'h12345678;
    axi_read(8'h1C, 32'h12345678, 2'b00);

    axi_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(8'h08, 32'h11223344, 4'b0101, 0, 0);
    axi_read(8'h0A, STRB_EN ? 32'hAA22CC44 : 32'h11223344, 2'b00);

    // Same-edge read and write of register 3.
    axi_write(8'h0C, 32'h9, 4'hF, 0, 0);
    e.data = 32'h9; e.resp = 2'b00;
    rq.push_back(e);
    e.data = 32'h0;
    bq.push_back(e);
    model[3] = 32'h5;
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = 8'h0C;
    AWVALID = 1'b1; AWADDR = 8'h0C; WVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF;
    @(negedge ACLK);
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    chk("same_rvalid", RVALID, 1);
    chk("same_bvalid", BVALID, 1);
    e = rq.pop_front();
    chk("same_rdata_old", RDATA, e.data);
    chk("same_rresp", RRESP, e.resp);
    e = bq.pop_front();
    chk("same_bresp", BRESP, e.resp);
    chk("same_reg3_new", Reg_Out[3*32 +: 32], 32'h5);
    RREADY = 1'b1; BREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0; BREADY = 1'b0;
    chk("same_rvalid_clear", RVALID, 0);
    chk("same_bvalid_clear", BVALID, 0);

    // Asynchronous reset while a read response waits for RREADY.
    e.data = 32'hDEADBEEF; e.resp = 2'b00;
    rq.push_back(e);
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = 8'h04;
    @(negedge ACLK);
    ARVALID = 1'b0;
    e = rq.pop_front();
    chk("prerst_rvalid", RVALID, 1);
    chk("prerst_rdata", RDATA, e.data);
    #2 ARESET = 1'b1;
    #1;
    for (int i = 0; i < NREGS - 1; i++) model[i] = 32'h0;
    chk("arst_rvalid", RVALID, 0);
    chk("arst_arready", ARREADY, 1);
    chk("arst_rdata", RDATA, 0);
    chk_regs("arst_reg_out");
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("postrst_rvalid", RVALID, 0);
    chk("postrst_bvalid", BVALID, 0);
    axi_read(8'h04, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_responder.md
# axi_lite_reg_responder

AXI4-Lite responder (slave) exposing a bank of 32-bit control/status registers to an AXI-Lite initiator. Sits at the peripheral end of the bus that the reader/writer masters drive, e.g. in front of the SPI controller's configuration registers. Read and write channels run as independent state machines. Out-of-range or read-only accesses are answered with SLVERR instead of stalling the bus.

## Interface
- ADDR_W, 8, byte-address width of AWADDR/ARADDR
- NREGS, 8, number of 32-bit registers; index NREGS-1 is the read-only status register
- ACLK  in  1  bus clock, all logic rising-edge
- ARESET  in  1  reset; one clock, asynchronous, active-high
- AWVALID / AWREADY  in / out  1  write-address handshake
- AWADDR  in  ADDR_W  write byte address
- WVALID / WREADY  in / out  1  write-data handshake
- WDATA  in  32  write data
- WSTRB  in  4  byte strobes, honoured only with AXIL_RESP_WSTRB_EN
- BVALID / BREADY  out / in  1  write-response handshake
- BRESP  out  2  write response
- ARVALID / ARREADY  in / out  1  read-address handshake
- ARADDR  in  ADDR_W  read byte address
- RVALID / RREADY  out / in  1  read-data handshake
- RDATA  out  32  read data
- RRESP  out  2  read response
- Status_In  in  32  value returned for register NREGS-1
- Reg_Out  out  32*NREGS-32  flattened writable registers; register i at bits [32i+31:32i]
- Wr_Pulse  out  1  one-cycle strobe when a write commits to a valid register
- Wr_Index  out  clog2(NREGS)  index of the last committed write

## Operation
- Reset values: all handshake outputs 0 except AWREADY=WREADY=ARREADY=1; BRESP=RRESP=00, RDATA=0, registers 0, Wr_Pulse=0, Wr_Index=0.
- Decode: index = addr[ADDR_W-1:2]. addr[1:0] is ignored (no misalignment error). Valid write requires index < NREGS-1. Valid read requires index < NREGS.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are accepted independently. AWREADY deasserts once AW is captured; WREADY deasserts once W is captured.
  - When both are held (same edge allowed): commit, set BVALID=1, enter W_RESP.
  - Valid target: register updated, Wr_Pulse=1 for one cycle, Wr_Index=index, BRESP=00 (OKAY).
  - Invalid or read-only target: no register change, no Wr_Pulse, BRESP=10 (SLVERR).
  - In W_RESP, hold BVALID/BRESP until BREADY. On the handshake edge: BVALID=0, AWREADY=WREADY=1, return to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE, ARREADY=1. On ARVALID: capture, register RDATA/RRESP, RVALID=1, ARREADY=0, enter R_DATA.
  - Invalid index: RDATA=0, RRESP=10. Index NREGS-1 returns Status_In sampled at the AR handshake edge.
  - In R_DATA, hold RDATA/RRESP/RVALID stable until RREADY. On the handshake edge: RVALID=0, ARREADY=1, return to R_IDLE.
- Simultaneous read and write of the same register on one edge: read returns the pre-write value.

## Timing
- Read latency: AR handshake at edge k → RVALID=1 after edge k. Minimum 2 cycles per read (ARREADY low during R_DATA).
- Write latency: last of AW/W handshaked at edge k → BVALID=1 and Wr_Pulse=1 after edge k. Register update is visible on Reg_Out in the same cycle.
- Back-to-back: ARREADY/AWREADY/WREADY reassert in the cycle after the response handshake. No outstanding-transaction buffering.
- ARESET asserted mid-transaction: immediate asynchronous return to reset values. Pending transaction dropped with no response.
- Outputs held stable while VALID=1 and READY=0.

## Configuration
- AXIL_RESP_WSTRB_EN defined: byte lane b is written only if WSTRB[b]=1. WSTRB=0000 to a valid register gives OKAY, data unchanged, Wr_Pulse still fires.
- Undefined: WSTRB is ignored and all 32 bits are written.

## Structure
- Package axil_resp_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - write-FSM and read-FSM state encodings
  - address-to-index decode function
- Sub-module axil_resp_regbank contains the register array, strobe merge, status mux and write pulse. The top contains both FSMs and handshakes.

## Test plan
- Write 0xDEADBEEF to 0x04 with AW and W on the same cycle, BREADY=1 → BRESP=00, Wr_Pulse one cycle, Wr_Index=1. Read 0x04 → RDATA=0xDEADBEEF, RRESP=00.
- W presented 3 cycles before AW, BREADY held low 5 cycles → BVALID and BRESP stay stable, WREADY low until the B handshake. Single commit.
- Write to 0x1C (status) and to 0x40 → BRESP=10, no Reg_Out change. Read 0x40 → RDATA=0, RRESP=10. Read 0x1C with Status_In=0x12345678 → 0x12345678, RRESP=00.
- With AXIL_RESP_WSTRB_EN: write 0xAABBCCDD, then 0x11223344 with WSTRB=0101 to 0x08 → reads 0xAA22CC44. Without the macro → 0x11223344.
- Read 0x0C and write 0x0C=0x5 on the same edge, old value 0x9 → RDATA=0x9, then Reg_Out[3]=0x5.
- ARESET pulsed while RVALID=1 awaiting RREADY → RVALID=0, ARREADY=1 immediately, registers 0.
